// File: rtl/delay_arbiter_pkg.sv
// Shared types and defaults for the delay arbiter: FSM state encoding and default counter width.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DelayWDefault = 32;

endpackage

// File: rtl/delay_arbiter_counter.sv
// Cycle-delay counter: load zeroes the count and latches the target, the count then climbs to the
// target and holds there; hit flags equality, clr zeroes the count.
module delay_arbiter_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [Width-1:0] m_i,
    output logic [Width-1:0] count_o,
    output logic             hit_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] m_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
            m_q     <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
            m_q     <= m_i;
        end else if (!hit_o) begin
            // Equality stop means a target of all-ones never wraps.
            count_q <= count_q + Width'(1);
        end
    end

    assign hit_o   = (count_q == m_q);
    assign count_o = count_q;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay counter among NReq requesters; the owner gets a DONE pulse
// after its latched delay elapses, or loses the grant silently if it drops its request.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int unsigned NReq  = 4,
    parameter int unsigned Width = DelayWDefault
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic [NReq-1:0]       req_i,
    input  logic [NReq*Width-1:0] m_flat_i,
    output logic [NReq-1:0]       grant_o,
    output logic [NReq-1:0]       done_o,
    output logic                  busy_o,
    output logic [Width-1:0]      count_o
);

    localparam int unsigned IdxW = $clog2(NReq);

    state_e           state_q;
    logic [NReq-1:0]  grant_q;
    logic [NReq-1:0]  done_q;
    logic             busy_q;
    logic [IdxW-1:0]  owner_q;
    logic [IdxW-1:0]  rr_ptr_q;

    logic [IdxW-1:0]  winner;
    logic [Width-1:0] m_sel;
    logic             owner_req;
    logic             cnt_load;
    logic             cnt_clr;
    logic             cnt_hit;

    // First requester strictly after ptr, wrapping; ptr itself is searched last.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NReq-1:0] req,
                                                input logic [IdxW-1:0] ptr);
        logic [IdxW-1:0] win;
        logic [IdxW-1:0] cand;
        logic            found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NReq; i++) begin
            cand = IdxW'((32'(ptr) + i) % NReq);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner    = rr_pick(req_i, rr_ptr_q);
    assign owner_req = req_i[owner_q];

    always_comb begin
        m_sel = '0;
        for (int unsigned i = 0; i < NReq; i++) begin
            if (32'(winner) == i) begin
                m_sel = m_flat_i[i*Width +: Width];
            end
        end
    end

    always_comb begin
        cnt_load = (state_q == StIdle) && (req_i != '0);
        // Zero the count whenever the next state is not a continuing RUN.
        cnt_clr  = !cnt_load && !((state_q == StRun) && owner_req && !cnt_hit);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= IdxW'(NReq - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= '0;
                    if (req_i != '0) begin
                        grant_q  <= NReq'(1) << winner;
                        owner_q  <= winner;
                        rr_ptr_q <= winner;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    // Abort outranks a same-cycle completion.
                    if (!owner_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_hit) begin
                        grant_q <= '0;
                        done_q  <= grant_q;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    delay_arbiter_counter #(
        .Width(Width)
    ) u_counter (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .load_i  (cnt_load),
        .clr_i   (cnt_clr),
        .m_i     (m_sel),
        .count_o (count_o),
        .hit_o   (cnt_hit)
    );

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed scenarios plus randomized traffic, each checked cycle by cycle
// against a transaction-level model that times each grant by its start cycle.
module tb_delay_arbiter;

    localparam int unsigned NReq = 4;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NReq-1:0]   req;
    logic [NReq*W-1:0] m_flat;
    logic [NReq-1:0]   grant;
    logic [NReq-1:0]   done;
    logic              busy;
    logic [W-1:0]      count;

    int checks = 0;
    int errors = 0;

    // Model: owner and its grant cycle; count is elapsed cycles since that grant.
    int            mo_owner;
    int            mo_done;
    int            mo_rr;
    longint        mo_start;
    longint        mo_cyc;
    longint        mo_m;
    logic [NReq-1:0] exp_grant;
    logic [NReq-1:0] exp_done;
    logic            exp_busy;
    logic [W-1:0]    exp_count;

    delay_arbiter #(
        .NReq (NReq),
        .Width(W)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .req_i   (req),
        .m_flat_i(m_flat),
        .grant_o (grant),
        .done_o  (done),
        .busy_o  (busy),
        .count_o (count)
    );

    always #5 clk = ~clk;

    task automatic model_outputs();
        exp_grant = (mo_owner >= 0) ? (NReq'(1) << mo_owner) : '0;
        exp_done  = (mo_done >= 0) ? (NReq'(1) << mo_done) : '0;
        exp_busy  = (mo_owner >= 0) || (mo_done >= 0);
        exp_count = (mo_owner >= 0) ? W'(mo_cyc - mo_start) : '0;
    endtask

    task automatic model_reset();
        mo_owner = -1;
        mo_done  = -1;
        mo_rr    = NReq - 1;
        mo_cyc   = 0;
        mo_start = 0;
        mo_m     = 0;
        model_outputs();
    endtask

    task automatic model_edge();
        mo_cyc++;
        if (mo_done >= 0) begin
            mo_done = -1;
        end else if (mo_owner < 0) begin
            if (req != '0) begin
                for (int k = 1; k <= NReq; k++) begin
                    int c;
                    c = (mo_rr + k) % NReq;
                    if (mo_owner < 0 && req[c]) mo_owner = c;
                end
                mo_rr    = mo_owner;
                mo_start = mo_cyc;
                mo_m     = longint'(m_flat[mo_owner*W +: W]);
            end
        end else if (!req[mo_owner]) begin
            mo_owner = -1;
        end else if (mo_cyc - 1 - mo_start == mo_m) begin
            mo_done  = mo_owner;
            mo_owner = -1;
        end
        model_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_m(input int i, input int v);
        m_flat[i*W +: W] = W'(v);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = '1;
        m_flat = '0;
        #1;
        checks++;
        if ({grant, done, busy, count} !== '0) begin
            errors++;
            $display("FAIL reset_async got g=%b d=%b b=%b c=%0d want all 0", grant, done, busy, count);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({grant, done, busy, count} !== '0) begin
            errors++;
            $display("FAIL reset_held got g=%b d=%b b=%b c=%0d want all 0", grant, done, busy, count);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int gcyc = 0;
        int dcnt = 0;
        int cmax = 0;
        apply_reset();
        set_m(1, 3);
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL single cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (grant == 4'b0010) begin
                gcyc++;
                if (int'(count) > cmax) cmax = int'(count);
            end
            if (done == 4'b0010) begin
                dcnt++;
                req = '0;
            end
        end
        checks++;
        if (gcyc != 4 || dcnt != 1 || cmax != 3) begin
            errors++;
            $display("FAIL single_shape got grant_cycles=%0d dones=%0d max_count=%0d want 4 1 3",
                     gcyc, dcnt, cmax);
        end
    endtask

    task automatic test_contention();
        int order[$];
        logic [NReq-1:0] prev_g = '0;
        apply_reset();
        for (int i = 0; i < NReq; i++) set_m(i, 1);
        req = '1;
        for (int c = 0; c < 18; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL contention cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (grant != '0 && prev_g == '0) begin
                for (int i = 0; i < NReq; i++) if (grant[i]) order.push_back(i);
            end
            prev_g = grant;
            for (int i = 0; i < NReq; i++) if (done[i]) req[i] = 1'b0;
        end
        checks++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3)
        begin
            errors++;
            $display("FAIL contention_order got %p want '{0,1,2,3}", order);
        end
    endtask

    task automatic test_zero();
        int gt = -1;
        int dt = -1;
        int gcyc = 0;
        apply_reset();
        set_m(0, 0);
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL zero cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (grant == 4'b0001) begin
                gcyc++;
                if (gt < 0) gt = c;
            end
            if (done == 4'b0001 && dt < 0) begin
                dt  = c;
                req = '0;
            end
        end
        checks++;
        if (gcyc != 1 || dt != gt + 1) begin
            errors++;
            $display("FAIL zero_shape got grant_cycles=%0d grant_at=%0d done_at=%0d want 1 g+1",
                     gcyc, gt, dt);
        end
    endtask

    task automatic test_abort();
        int dseen = 0;
        apply_reset();
        set_m(2, 10);
        req = 4'b0100;
        for (int c = 0; c < 18; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL abort cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (done[2]) dseen++;
            if (c == 4) begin
                checks++;
                if (count !== W'(4)) begin
                    errors++;
                    $display("FAIL abort_pre got count=%0d want 4", count);
                end
                req = '0;
            end
            if (c == 5) begin
                checks++;
                if ({grant, busy, count} !== '0) begin
                    errors++;
                    $display("FAIL abort_post got g=%b b=%b c=%0d want 0 0 0", grant, busy, count);
                end
            end
        end
        checks++;
        if (dseen != 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d done pulses want 0", dseen);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_m(1, 20);
        req = 4'b0010;
        repeat (6) tick();
        checks++;
        if (count !== W'(5) || grant !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_pre got g=%b c=%0d want 0010 5", grant, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, done, busy, count} !== '0) begin
            errors++;
            $display("FAIL midreset_async got g=%b d=%b b=%b c=%0d want all 0",
                     grant, done, busy, count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 26; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL midreset cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (c == 0) begin
                checks++;
                if (grant !== 4'b0010 || count !== '0) begin
                    errors++;
                    $display("FAIL midreset_restart got g=%b c=%0d want 0010 0", grant, count);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int order[$];
        logic [NReq-1:0] prev_g = '0;
        apply_reset();
        for (int i = 0; i < NReq; i++) set_m(i, 2);
        req = 4'b1001;
        for (int c = 0; c < 21; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL fairness cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (grant != '0 && prev_g == '0) begin
                for (int i = 0; i < NReq; i++) if (grant[i]) order.push_back(i);
            end
            prev_g = grant;
        end
        checks++;
        if (order.size() < 4 || order[0] != 0 || order[1] != 3 || order[2] != 0 || order[3] != 3)
        begin
            errors++;
            $display("FAIL fairness_order got %p want '{0,3,0,3}", order);
        end
    endtask

    task automatic test_max_delay();
        int gcyc = 0;
        int dcnt = 0;
        apply_reset();
        set_m(3, (1 << W) - 1);
        req = 4'b1000;
        for (int c = 0; c < (1 << W) + 4; c++) begin
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL maxdelay cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
            if (grant[3]) gcyc++;
            if (done[3]) begin
                dcnt++;
                req = '0;
            end
        end
        checks++;
        if (gcyc != (1 << W) || dcnt != 1) begin
            errors++;
            $display("FAIL maxdelay_shape got grant_cycles=%0d dones=%0d want %0d 1",
                     gcyc, dcnt, 1 << W);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NReq; i++) begin
                if ($urandom_range(19) == 0) set_m(i, $urandom_range(40));
                else set_m(i, $urandom_range(5));
                if (req[i]) begin
                    if ($urandom_range(24) == 0 || (done[i] && $urandom_range(1) == 0)) req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            tick();
            checks++;
            if ({grant, done, busy, count} !== {exp_grant, exp_done, exp_busy, exp_count}) begin
                errors++;
                $display("FAIL random cyc%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         c, grant, done, busy, count, exp_grant, exp_done, exp_busy, exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero();
        test_abort();
        test_reset_mid();
        test_fairness();
        test_max_delay();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
